// File: rtl/network_pkg.sv
// Shared types and constants for the bitstream network run controller.
package network_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_COMPUTE = 4'd2,
        ST_CAPTURE = 4'd3,
        ST_DONE    = 4'd4
    } seq_state_t;

    localparam int STATUS_DONE      = 0;
    localparam int STATUS_CONT      = 1;
    localparam int STATUS_VALID     = 2;
    localparam int STATUS_BUSY      = 3;
    localparam int STATUS_STATE_LSB = 4;

    localparam int DEFAULT_LEN_WIDTH = 8;

endpackage

// File: rtl/network_sequencer_network.sv
// Bitstream network core: while compute is high, every output accumulates
// the sum of all operands plus its own output index.
module network #(
    parameter int INPUT_SIZE  = 2,
    parameter int OUTPUT_SIZE = 1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic compute,
    input  int   data_in  [0:INPUT_SIZE-1],
    output int   data_out [0:OUTPUT_SIZE-1]
);

    int operand_sum;

    always_comb begin
        operand_sum = 0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            operand_sum = operand_sum + data_in[i];
        end
    end

    generate
        for (genvar gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_out
            int acc_reg;

            always_ff @(posedge clk or negedge n_rst) begin
                if (!n_rst) begin
                    acc_reg <= 0;
                end else if (compute) begin
                    acc_reg <= acc_reg + operand_sum + gi;
                end
            end

            assign data_out[gi] = acc_reg;
        end
    endgenerate

endmodule

// File: rtl/network_sequencer.sv
// Run controller: snapshots operands and length, clears the network, runs it
// for stream_len+1 compute cycles and holds the captured result.
module network_sequencer
    import network_pkg::*;
#(
    parameter int INPUT_SIZE  = 2,
    parameter int OUTPUT_SIZE = 1,
    parameter int LEN_WIDTH   = DEFAULT_LEN_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 continuous,
    input  logic [LEN_WIDTH-1:0] stream_len,
    input  int                   data_in  [0:INPUT_SIZE-1],
    output int                   data_out [0:OUTPUT_SIZE-1],
    output logic                 result_valid,
    output logic                 done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] run_count,
    output logic [7:0]           status
);

    seq_state_t           state_reg;
    seq_state_t           state_next;
    logic                 latch_en;
    logic                 abort_run;

    int                   data_snap_reg [0:INPUT_SIZE-1];
    logic [LEN_WIDTH-1:0] len_snap_reg;
    logic                 cont_snap_reg;
    logic [LEN_WIDTH:0]   place_reg;
    logic                 last_place;

    int                   data_out_reg [0:OUTPUT_SIZE-1];
    int                   net_out      [0:OUTPUT_SIZE-1];
    logic                 result_valid_reg;
    logic                 done_reg;
    logic [CNT_WIDTH-1:0] run_count_reg;

    logic                 compute;
    logic                 net_clear;
    logic                 net_rst_n;

    assign abort_run  = abort && (state_reg != ST_IDLE);
    // Extra counter bit lets an all-ones length run 2^LEN_WIDTH cycles.
    assign last_place = (place_reg == {1'b0, len_snap_reg});

    always_comb begin
        state_next = state_reg;
        latch_en   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_LOAD;
                    latch_en   = 1'b1;
                end
            end
            ST_LOAD:    state_next = ST_COMPUTE;
            ST_COMPUTE: if (last_place) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_DONE;
            ST_DONE: begin
                if (cont_snap_reg) begin
                    state_next = ST_LOAD;
                    latch_en   = 1'b1;
                end else if (!start) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort_run) begin
            state_next = ST_IDLE;
            latch_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg        <= ST_IDLE;
            len_snap_reg     <= '0;
            cont_snap_reg    <= 1'b0;
            place_reg        <= '0;
            result_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
            run_count_reg    <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) data_snap_reg[i] <= 0;
            for (int j = 0; j < OUTPUT_SIZE; j++) data_out_reg[j] <= 0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_CAPTURE) && (state_next == ST_DONE);

            if (latch_en) begin
                len_snap_reg     <= stream_len;
                cont_snap_reg    <= continuous;
                result_valid_reg <= 1'b0;
                for (int i = 0; i < INPUT_SIZE; i++) data_snap_reg[i] <= data_in[i];
            end

            if (state_reg == ST_LOAD) begin
                place_reg <= '0;
            end else if (state_reg == ST_COMPUTE) begin
                place_reg <= place_reg + 1'b1;
            end

            if (abort_run) begin
                result_valid_reg <= 1'b0;
            end else if (state_reg == ST_CAPTURE) begin
                result_valid_reg <= 1'b1;
                run_count_reg    <= run_count_reg + 1'b1;
                for (int j = 0; j < OUTPUT_SIZE; j++) data_out_reg[j] <= net_out[j];
            end
        end
    end

    // Abort kills compute in the same cycle, before the state register reacts.
    assign compute   = (state_reg == ST_COMPUTE) && !abort;
    assign net_clear = (state_reg == ST_LOAD);
    assign net_rst_n = n_rst && !net_clear;

    network #(
        .INPUT_SIZE  (INPUT_SIZE),
        .OUTPUT_SIZE (OUTPUT_SIZE)
    ) u_network (
        .clk      (clk),
        .n_rst    (net_rst_n),
        .compute  (compute),
        .data_in  (data_snap_reg),
        .data_out (net_out)
    );

    assign busy = (state_reg == ST_LOAD) || (state_reg == ST_COMPUTE) ||
                  (state_reg == ST_CAPTURE);

    generate
        for (genvar gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_dout
            assign data_out[gi] = data_out_reg[gi];
        end
    endgenerate

    assign result_valid = result_valid_reg;
    assign done         = done_reg;
    assign run_count    = run_count_reg;

    always_comb begin
        status                           = '0;
        status[STATUS_STATE_LSB +: 4]    = state_reg;
        status[STATUS_BUSY]              = busy;
        status[STATUS_VALID]             = result_valid_reg;
        status[STATUS_CONT]              = cont_snap_reg;
        status[STATUS_DONE]              = done_reg;
    end

endmodule

// File: tb/tb_network_sequencer.sv
// Directed bench for network_sequencer: basic, max-length, abort, continuous,
// held-start and mid-run reset scenarios.
module tb_network_sequencer;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       abort;
    logic       continuous;
    logic [7:0] stream_len;
    int         data_in  [0:1];
    int         data_out [0:0];
    logic       result_valid;
    logic       done;
    logic       busy;
    logic [15:0] run_count;
    logic [7:0] status;

    int checks = 0;
    int errors = 0;
    int comp_total = 0;
    int done_total = 0;
    int c0;
    int d0;

    network_sequencer #(
        .INPUT_SIZE  (2),
        .OUTPUT_SIZE (1),
        .LEN_WIDTH   (8),
        .CNT_WIDTH   (16)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .abort        (abort),
        .continuous   (continuous),
        .stream_len   (stream_len),
        .data_in      (data_in),
        .data_out     (data_out),
        .result_valid (result_valid),
        .done         (done),
        .busy         (busy),
        .run_count    (run_count),
        .status       (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.compute) comp_total <= comp_total + 1;
        if (done) done_total <= done_total + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
        stream_len = 8'd0; data_in[0] = 0; data_in[1] = 0;
        tick(2);
        check("rst_status", 32'(status), 32'h00);
        check("rst_data_out", 32'(data_out[0]), 32'd0);
        check("rst_run_count", 32'(run_count), 32'd0);
        check("rst_valid_busy_done", {29'd0, result_valid, busy, done}, 32'd0);
        n_rst = 1'b1;
        tick(1);

        // Basic run: sum 12, L=4; inputs changed after the start edge are ignored
        data_in[0] = 5; data_in[1] = 7; stream_len = 8'd3;
        c0 = comp_total;
        start = 1'b1; tick(1); start = 1'b0;
        check("basic_load_status", 32'(status), 32'h18);
        data_in[0] = 100; data_in[1] = 100; stream_len = 8'd9;
        tick(5);
        check("basic_capture_status", 32'(status), 32'h38);
        tick(1);
        check("basic_done_status", 32'(status), 32'h45);
        check("basic_data_out", 32'(data_out[0]), 32'd48);
        check("basic_run_count", 32'(run_count), 32'd1);
        check("basic_compute_cycles", 32'(comp_total - c0), 32'd4);
        tick(1);
        check("basic_idle_status", 32'(status), 32'h04);

        // Maximum length: 256 compute cycles, sum 3
        data_in[0] = 1; data_in[1] = 2; stream_len = 8'd255;
        c0 = comp_total;
        start = 1'b1; tick(1); start = 1'b0;
        tick(257);
        check("max_capture_done", {31'd0, done}, 32'd0);
        tick(1);
        check("max_done", {31'd0, done}, 32'd1);
        check("max_data_out", 32'(data_out[0]), 32'd768);
        check("max_compute_cycles", 32'(comp_total - c0), 32'd256);
        check("max_run_count", 32'(run_count), 32'd2);
        tick(1);

        // Abort in the 10th compute cycle of a 32-cycle run
        data_in[0] = 3; data_in[1] = 4; stream_len = 8'd31;
        c0 = comp_total; d0 = done_total;
        start = 1'b1; tick(1); start = 1'b0;
        tick(10);
        check("abort_pre_state", 32'(status[7:4]), 32'd2);
        abort = 1'b1; #1;
        check("abort_compute_low", {31'd0, dut.compute}, 32'd0);
        tick(1); abort = 1'b0;
        check("abort_idle_status", 32'(status), 32'h00);
        check("abort_data_out", 32'(data_out[0]), 32'd768);
        check("abort_run_count", 32'(run_count), 32'd2);
        check("abort_compute_cycles", 32'(comp_total - c0), 32'd9);
        tick(2);
        check("abort_no_done", 32'(done_total - d0), 32'd0);

        // Continuous: L=8, period 11, sum 4
        data_in[0] = 2; data_in[1] = 2; stream_len = 8'd7; continuous = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        tick(10);
        check("cont1_status", 32'(status), 32'h47);
        check("cont1_data_out", 32'(data_out[0]), 32'd32);
        check("cont1_run_count", 32'(run_count), 32'd3);
        tick(1);
        check("cont1_reload_state", 32'(status), 32'h1a);
        tick(10);
        check("cont2_status", 32'(status), 32'h47);
        check("cont2_run_count", 32'(run_count), 32'd4);
        continuous = 1'b0;
        tick(11);
        check("cont3_status", 32'(status), 32'h45);
        check("cont3_run_count", 32'(run_count), 32'd5);
        tick(1);
        check("cont_stop_idle", 32'(status), 32'h04);

        // Held start: L=1, sum 7; stays in DONE until start drops
        data_in[0] = 10; data_in[1] = -3; stream_len = 8'd0;
        start = 1'b1; tick(1);
        tick(3);
        check("held_done", 32'(status), 32'h45);
        check("held_data_out", 32'(data_out[0]), 32'd7);
        tick(3);
        check("held_stay_done", 32'(status), 32'h44);
        check("held_run_count", 32'(run_count), 32'd6);
        start = 1'b0; tick(1);
        check("held_drop_idle", 32'(status), 32'h04);
        start = 1'b1; tick(1); start = 1'b0;
        check("held_relaunch_load", 32'(status), 32'h18);
        tick(3);
        check("held_second_count", 32'(run_count), 32'd7);

        // Reset mid-run, then a fresh run
        tick(1);
        data_in[0] = 1; data_in[1] = 1; stream_len = 8'd15;
        start = 1'b1; tick(1); start = 1'b0;
        tick(4);
        n_rst = 1'b0; #1;
        check("midrst_status", 32'(status), 32'h00);
        check("midrst_data_out", 32'(data_out[0]), 32'd0);
        check("midrst_run_count", 32'(run_count), 32'd0);
        tick(1); n_rst = 1'b1;
        data_in[0] = 6; data_in[1] = 9; stream_len = 8'd2;
        c0 = comp_total;
        start = 1'b1; tick(1); start = 1'b0;
        tick(5);
        check("fresh_done_status", 32'(status), 32'h45);
        check("fresh_data_out", 32'(data_out[0]), 32'd45);
        check("fresh_run_count", 32'(run_count), 32'd1);
        check("fresh_compute_cycles", 32'(comp_total - c0), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
